// File: rtl/alu_sequencer_pkg.sv
// Shared constants and types for the calculator ALU front-end sequencer.
package calc_pkg;

  localparam int WIDTH     = 12;
  localparam int MUL_STEPS = 12;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Opcodes that are not single-pass ALU operations select the zero function.
  function automatic logic [2:0] alu_sel(input logic [2:0] op);
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_XOR:  alu_sel = ALU_XOR;
      default: alu_sel = ALU_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response channels between the command decoder and the result consumer.
interface alu_sequencer_if #(
  parameter int WIDTH = calc_pkg::WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_ovf;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/alu_sequencer_ovf_check.sv
// Signed two's-complement overflow detection for an ALU add or subtract.
module alu_ovf_check #(
  parameter int WIDTH = calc_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic unused_low_bits;
  assign unused_low_bits = ^{a[MSB-1:0], b[MSB-1:0], y[MSB-1:0]};

  // Subtract overflows only when operand signs differ; add only when they match.
  assign ovf = sub ? ((a[MSB] != b[MSB]) && (y[MSB] != a[MSB]))
                   : ((a[MSB] == b[MSB]) && (y[MSB] != a[MSB]));

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the external 12-bit ALU: single-pass ops plus shift-add MUL.
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH     = calc_pkg::WIDTH,
  parameter int MUL_STEPS = calc_pkg::MUL_STEPS
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy
);

  localparam int CW = $clog2(MUL_STEPS + 1);

  state_t           state, state_next;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             mul_ovf_q;
  logic [CW-1:0]    step_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_ovf_q, rsp_err_q;

  logic             accept;
  logic             exec_ovf;
  logic             mul_add, mul_done, mul_ovf_next;
  logic [WIDTH-1:0] acc_next, mcand_next, mplier_next;

  assign accept = bus.req_valid && (state == IDLE);

  // During MUL, a_q holds the shifting multiplicand and b_q the shifting multiplier.
  assign mul_add      = b_q[0];
  assign mplier_next  = b_q >> 1;
  assign mcand_next   = a_q << 1;
  assign acc_next     = mul_add ? alu_y : acc_q;
  assign mul_ovf_next = mul_ovf_q
                      | (mul_add && (alu_y < acc_q))
                      | (a_q[WIDTH-1] && (mplier_next != '0));
  assign mul_done     = (mplier_next == '0) || (step_q == CW'(MUL_STEPS - 1));

  alu_ovf_check #(.WIDTH(WIDTH)) u_ovf (
    .a   (a_q),
    .b   (b_q),
    .y   (alu_y),
    .sub (op_q == OP_SUB),
    .ovf (exec_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_a      = '0;
    alu_b      = '0;
    alu_s      = ALU_ZERO;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_op < OP_MUL)       state_next = EXEC;
          else if (bus.req_op == OP_MUL) state_next = MUL;
          else                           state_next = RESP;
        end
      end
      EXEC: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_s      = alu_sel(op_q);
        state_next = RESP;
      end
      MUL: begin
        if (mul_add) begin
          alu_a = acc_q;
          alu_b = a_q;
          alu_s = ALU_ADD;
        end
        if (mul_done) state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, the shift-add loop and the response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      mul_ovf_q    <= 1'b0;
      step_q       <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= bus.req_op;
            a_q       <= bus.req_a;
            b_q       <= bus.req_b;
            acc_q     <= '0;
            mul_ovf_q <= 1'b0;
            step_q    <= '0;
            if (bus.req_op > OP_MUL) begin
              rsp_result_q <= '0;
              rsp_ovf_q    <= 1'b0;
              rsp_err_q    <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_result_q <= alu_y;
          rsp_ovf_q    <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? exec_ovf : 1'b0;
          rsp_err_q    <= 1'b0;
        end
        MUL: begin
          acc_q     <= acc_next;
          a_q       <= mcand_next;
          b_q       <= mplier_next;
          mul_ovf_q <= mul_ovf_next;
          step_q    <= step_q + CW'(1);
          if (mul_done) begin
            rsp_result_q <= acc_next;
            rsp_ovf_q    <= mul_ovf_next;
            rsp_err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state != IDLE);

endmodule
